// File: rtl/sgx_pkg.sv
// Shared types for the SGX enclave page-cache controller: opcodes, status codes,
// enclave lifecycle and controller FSM states, plus the page index helper.
package sgx_pkg;

    typedef enum logic [2:0] {
        ECREATE  = 3'd0,
        EADD     = 3'd1,
        EINIT    = 3'd2,
        EENTER   = 3'd3,
        EEXIT    = 3'd4,
        EREMOVE  = 3'd5,
        EREPORT  = 3'd6,
        EDESTROY = 3'd7
    } sgx_op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_ERR_STATE = 2'd1,
        ST_ERR_PAGE  = 2'd2,
        ST_ERR_BUSY  = 2'd3
    } sgx_status_e;

    typedef enum logic [1:0] {
        ENC_FREE    = 2'd0,
        ENC_CREATED = 2'd1,
        ENC_INITED  = 2'd2
    } encl_state_e;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_EXEC  = 2'd1,
        FSM_SWEEP = 2'd2,
        FSM_RESP  = 2'd3
    } ctrl_state_e;

    // Caller truncates to the index width; upper bits alias by design.
    function automatic logic [63:0] page_idx(input logic [63:0] addr, input int unsigned lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/sgx_epcm_table.sv
// EPCM storage: per-page valid bit and owner enclave id, one read-only lookup
// port for the LSU access check and one lookup + write port for the controller.
module sgx_epcm_table #(
    parameter int  EPC_PAGES = 256,
    parameter int  EID_W     = 2,
    localparam int IDX_W     = $clog2(EPC_PAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] acc_idx_i,
    output logic             acc_valid_o,
    output logic [EID_W-1:0] acc_owner_o,
    input  logic [IDX_W-1:0] lk_idx_i,
    output logic             lk_valid_o,
    output logic [EID_W-1:0] lk_owner_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_valid_i,
    input  logic [EID_W-1:0] wr_owner_i
);

    logic [EPC_PAGES-1:0] valid_q;
    logic [EPC_PAGES-1:0] valid_d;
    logic [EID_W-1:0]     owner_q [EPC_PAGES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = wr_valid_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Owner is only meaningful while valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i && wr_valid_i) begin
            owner_q[wr_idx_i] <= wr_owner_i;
        end
    end

    assign acc_valid_o = valid_q[acc_idx_i];
    assign acc_owner_o = owner_q[acc_idx_i];
    assign lk_valid_o  = valid_q[lk_idx_i];
    assign lk_owner_o  = owner_q[lk_idx_i];

endmodule

// File: rtl/sgx_epc_ctrl.sv
// Multi-enclave SGX controller: handshaked privileged-op channel, per-enclave
// lifecycle and measurement, EPCM ownership and the LSU access fault check.
module sgx_epc_ctrl
    import sgx_pkg::*;
#(
    parameter int  NUM_ENCLAVES = 4,
    parameter int  EPC_PAGES    = 256,
    parameter int  PAGE_LSB     = 8,
    localparam int EID_W        = (NUM_ENCLAVES > 1) ? $clog2(NUM_ENCLAVES) : 1,
    localparam int IDX_W        = $clog2(EPC_PAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  sgx_op_e          cmd_op_i,
    input  logic [EID_W-1:0] cmd_eid_i,
    input  logic [63:0]      cmd_addr_i,
    input  logic [63:0]      cmd_wdata_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [1:0]       resp_status_o,
    output logic [63:0]      resp_data_o,
    input  logic             access_valid_i,
    input  logic [63:0]      access_addr_i,
    output logic             access_fault_o,
    output logic             active_o,
    output logic [EID_W-1:0] active_eid_o
);

    ctrl_state_e      state_q, state_d;
    sgx_op_e          op_q, op_d;
    logic [EID_W-1:0] eid_q, eid_d;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    sgx_status_e      status_q, status_d;
    logic [63:0]      data_q, data_d;
    logic             active_q, active_d;
    logic [EID_W-1:0] active_eid_q, active_eid_d;
    encl_state_e      encl_q [NUM_ENCLAVES];
    encl_state_e      encl_d [NUM_ENCLAVES];
    logic [63:0]      meas_q [NUM_ENCLAVES];
    logic [63:0]      meas_d [NUM_ENCLAVES];

    logic [IDX_W-1:0] acc_idx, lk_idx, wr_idx;
    logic             acc_valid, lk_valid, wr_en, wr_valid;
    logic [EID_W-1:0] acc_owner, lk_owner;
    sgx_status_e      err;
    logic             eid_ok, eid_running, page_mine;
    encl_state_e      cur_st;

    assign acc_idx = IDX_W'(page_idx(access_addr_i, PAGE_LSB));

    sgx_epcm_table #(
        .EPC_PAGES (EPC_PAGES),
        .EID_W     (EID_W)
    ) u_epcm (
        .clk         (clk),
        .rst_n       (rst_n),
        .acc_idx_i   (acc_idx),
        .acc_valid_o (acc_valid),
        .acc_owner_o (acc_owner),
        .lk_idx_i    (lk_idx),
        .lk_valid_o  (lk_valid),
        .lk_owner_o  (lk_owner),
        .wr_en_i     (wr_en),
        .wr_idx_i    (wr_idx),
        .wr_valid_i  (wr_valid),
        .wr_owner_i  (eid_q)
    );

    always_comb begin
        eid_ok      = int'(eid_q) < NUM_ENCLAVES;
        cur_st      = encl_q[eid_q];
        eid_running = active_q && (active_eid_q == eid_q);
        page_mine   = lk_valid && (lk_owner == eid_q);
        err         = ST_OK;
        // Checks are ordered so the higher-precedence status is the one kept.
        case (op_q)
            ECREATE:  if (cur_st != ENC_FREE) err = ST_ERR_STATE;
                      else if (lk_valid) err = ST_ERR_PAGE;
            EADD:     if (cur_st != ENC_CREATED) err = ST_ERR_STATE;
                      else if (lk_valid) err = ST_ERR_PAGE;
            EINIT:    if (cur_st != ENC_CREATED) err = ST_ERR_STATE;
            EENTER:   if (cur_st != ENC_INITED || active_q) err = ST_ERR_STATE;
            EEXIT:    if (!eid_running) err = ST_ERR_STATE;
            EREMOVE:  if (eid_running) err = ST_ERR_BUSY;
                      else if (!page_mine) err = ST_ERR_PAGE;
            EREPORT:  if (cur_st == ENC_FREE) err = ST_ERR_STATE;
            EDESTROY: if (cur_st == ENC_FREE) err = ST_ERR_STATE;
                      else if (eid_running) err = ST_ERR_BUSY;
            default:  err = ST_ERR_STATE;
        endcase
        if (!eid_ok) begin
            err = ST_ERR_STATE;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        eid_d        = eid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sweep_d      = sweep_q;
        status_d     = status_q;
        data_d       = data_q;
        active_d     = active_q;
        active_eid_d = active_eid_q;
        encl_d       = encl_q;
        meas_d       = meas_q;
        lk_idx       = IDX_W'(page_idx(addr_q, PAGE_LSB));
        wr_idx       = lk_idx;
        wr_en        = 1'b0;
        wr_valid     = 1'b0;
        case (state_q)
            FSM_IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    eid_d   = cmd_eid_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    state_d = FSM_EXEC;
                end
            end
            FSM_EXEC: begin
                status_d = err;
                data_d   = '0;
                state_d  = FSM_RESP;
                if (err == ST_OK) begin
                    case (op_q)
                        ECREATE: begin
                            wr_en          = 1'b1;
                            wr_valid       = 1'b1;
                            meas_d[eid_q]  = '0;
                            encl_d[eid_q]  = ENC_CREATED;
                        end
                        EADD: begin
                            wr_en         = 1'b1;
                            wr_valid      = 1'b1;
                            meas_d[eid_q] = {meas_q[eid_q][62:0], meas_q[eid_q][63]}
                                            ^ addr_q ^ wdata_q;
                        end
                        EINIT:    encl_d[eid_q] = ENC_INITED;
                        EENTER: begin
                            active_d     = 1'b1;
                            active_eid_d = eid_q;
                        end
                        EEXIT: begin
                            active_d     = 1'b0;
                            active_eid_d = '0;
                        end
                        EREMOVE:  wr_en  = 1'b1;
                        EREPORT:  data_d = meas_q[eid_q];
                        EDESTROY: begin
                            sweep_d = '0;
                            state_d = FSM_SWEEP;
                        end
                        default: ;
                    endcase
                end
            end
            FSM_SWEEP: begin
                lk_idx   = sweep_q;
                wr_idx   = sweep_q;
                wr_en    = page_mine;
                wr_valid = 1'b0;
                sweep_d  = sweep_q + 1'b1;
                if (sweep_q == IDX_W'(EPC_PAGES - 1)) begin
                    meas_d[eid_q] = '0;
                    encl_d[eid_q] = ENC_FREE;
                    state_d       = FSM_RESP;
                end
            end
            FSM_RESP: begin
                if (resp_ready_i) begin
                    status_d = ST_OK;
                    data_d   = '0;
                    state_d  = FSM_IDLE;
                end
            end
            default: state_d = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FSM_IDLE;
            op_q         <= ECREATE;
            eid_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            sweep_q      <= '0;
            status_q     <= ST_OK;
            data_q       <= '0;
            active_q     <= 1'b0;
            active_eid_q <= '0;
            for (int i = 0; i < NUM_ENCLAVES; i++) begin
                encl_q[i] <= ENC_FREE;
                meas_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            eid_q        <= eid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sweep_q      <= sweep_d;
            status_q     <= status_d;
            data_q       <= data_d;
            active_q     <= active_d;
            active_eid_q <= active_eid_d;
            encl_q       <= encl_d;
            meas_q       <= meas_d;
        end
    end

    assign cmd_ready_o    = (state_q == FSM_IDLE);
    assign resp_valid_o   = (state_q == FSM_RESP);
    assign resp_status_o  = status_q;
    assign resp_data_o    = data_q;
    assign active_o       = active_q;
    assign active_eid_o   = active_eid_q;
    assign access_fault_o = access_valid_i && active_q &&
                            !(acc_valid && (acc_owner == active_eid_q));

endmodule

// File: tb/tb_sgx_epc_ctrl.sv
// Directed self-checking bench for sgx_epc_ctrl: lifecycle, access faults,
// error codes, response hold, enclave teardown and reset during a sweep.
module tb_sgx_epc_ctrl;
    import sgx_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    sgx_op_e     cmd_op;
    logic [1:0]  cmd_eid;
    logic [63:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_status;
    logic [63:0] resp_data;
    logic        access_valid;
    logic [63:0] access_addr;
    logic        access_fault;
    logic        active;
    logic [1:0]  active_eid;

    int total = 0;
    int bad   = 0;

    sgx_epc_ctrl #(
        .NUM_ENCLAVES (4),
        .EPC_PAGES    (256),
        .PAGE_LSB     (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_op_i       (cmd_op),
        .cmd_eid_i      (cmd_eid),
        .cmd_addr_i     (cmd_addr),
        .cmd_wdata_i    (cmd_wdata),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_status_o  (resp_status),
        .resp_data_o    (resp_data),
        .access_valid_i (access_valid),
        .access_addr_i  (access_addr),
        .access_fault_o (access_fault),
        .active_o       (active),
        .active_eid_o   (active_eid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one command from the IDLE state, waits for the response and consumes it.
    // lat counts cycles from the accept cycle to the first cycle with resp_valid high.
    task automatic do_cmd(input sgx_op_e op, input logic [1:0] eid, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [1:0] st,
                          output logic [63:0] data, output int lat);
        int waits;
        waits     = 0;
        cmd_op    = op;
        cmd_eid   = eid;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!resp_valid && waits < 400) begin
            @(posedge clk); #1;
            waits++;
        end
        lat = waits + 1;
        st  = resp_status;
        data = resp_data;
        if (!resp_valid) begin
            total++;
            bad++;
            $display("FAIL resp_timeout op=%0d eid=%0d: no response within 400 cycles", op, eid);
        end
        $display("txn op=%0d eid=%0d addr=%h wdata=%h -> status=%0d data=%h lat=%0d",
                 op, eid, addr, wdata, st, data, lat);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = ECREATE;
        cmd_eid      = '0;
        cmd_addr     = '0;
        cmd_wdata    = '0;
        resp_ready   = 1'b0;
        access_valid = 1'b1;
        access_addr  = 64'h300;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cmd_ready, resp_valid, resp_status, resp_data, access_fault, active, active_eid}
            !== {1'b1, 1'b0, 2'd0, 64'd0, 1'b0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b rv=%b st=%0d data=%h fault=%b act=%b eid=%0d, need ready=1 rest 0",
                     cmd_ready, resp_valid, resp_status, resp_data, access_fault, active, active_eid);
        end
        rst_n = 1'b1;
        access_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lifecycle();
        logic [1:0] st; logic [63:0] d; int lat;
        do_cmd(ECREATE, 2'd1, 64'h100, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd0 || lat !== 2) begin
            bad++;
            $display("FAIL ecreate_e1: status=%0d lat=%0d, need status=0 lat=2", st, lat);
        end
        do_cmd(EADD, 2'd1, 64'h200, 64'hA5, st, d, lat);
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL eadd_e1_200: status=%0d need 0", st); end
        do_cmd(EADD, 2'd1, 64'h400, 64'h1, st, d, lat);
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL eadd_e1_400: status=%0d need 0", st); end
        do_cmd(EINIT, 2'd1, 64'h0, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL einit_e1: status=%0d need 0", st); end
        do_cmd(EENTER, 2'd1, 64'h0, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd0 || active !== 1'b1 || active_eid !== 2'd1) begin
            bad++;
            $display("FAIL eenter_e1: status=%0d active=%b eid=%0d, need 0/1/1", st, active, active_eid);
        end
    endtask

    task automatic test_access();
        logic [63:0] addrs [5];
        logic        exp   [5];
        addrs[0] = 64'h200;     exp[0] = 1'b0;
        addrs[1] = 64'h300;     exp[1] = 1'b1;
        addrs[2] = 64'h100;     exp[2] = 1'b0;
        addrs[3] = 64'h1_0200;  exp[3] = 1'b0;
        addrs[4] = 64'h1_0300;  exp[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            access_valid = 1'b1;
            access_addr  = addrs[i];
            #1;
            total++;
            $display("probe addr=%h fault=%b", addrs[i], access_fault);
            if (access_fault !== exp[i]) begin
                bad++;
                $display("FAIL access_probe addr=%h: fault=%b need %b", addrs[i], access_fault, exp[i]);
            end
        end
        access_valid = 1'b0;
        #1;
        total++;
        if (access_fault !== 1'b0) begin
            bad++;
            $display("FAIL access_novalid: fault=%b need 0", access_fault);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        logic [1:0] st; logic [63:0] d; int lat;
        sgx_op_e    ops  [9];
        logic [1:0] eids [9];
        logic [63:0] ads [9];
        logic [1:0] exps [9];
        ops[0] = ECREATE;  eids[0] = 2'd3; ads[0] = 64'h500; exps[0] = 2'd0;
        ops[1] = EADD;     eids[1] = 2'd3; ads[1] = 64'h200; exps[1] = 2'd2;
        ops[2] = EINIT;    eids[2] = 2'd3; ads[2] = 64'h0;   exps[2] = 2'd0;
        ops[3] = EENTER;   eids[3] = 2'd3; ads[3] = 64'h0;   exps[3] = 2'd1;
        ops[4] = EREMOVE;  eids[4] = 2'd1; ads[4] = 64'h200; exps[4] = 2'd3;
        ops[5] = EREMOVE;  eids[5] = 2'd3; ads[5] = 64'h200; exps[5] = 2'd2;
        ops[6] = EINIT;    eids[6] = 2'd1; ads[6] = 64'h0;   exps[6] = 2'd1;
        ops[7] = EEXIT;    eids[7] = 2'd3; ads[7] = 64'h0;   exps[7] = 2'd1;
        ops[8] = EDESTROY; eids[8] = 2'd1; ads[8] = 64'h0;   exps[8] = 2'd3;
        for (int i = 0; i < 9; i++) begin
            do_cmd(ops[i], eids[i], ads[i], 64'h0, st, d, lat);
            total++;
            if (st !== exps[i]) begin
                bad++;
                $display("FAIL err_vec%0d op=%0d eid=%0d: status=%0d need %0d",
                         i, ops[i], eids[i], st, exps[i]);
            end
        end
        total++;
        if (active !== 1'b1 || active_eid !== 2'd1) begin
            bad++;
            $display("FAIL errors_keep_active: active=%b eid=%0d need 1/1", active, active_eid);
        end
        // Freed page can be claimed again by another enclave.
        do_cmd(EREMOVE, 2'd3, 64'h500, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL eremove_e3: status=%0d need 0", st); end
        do_cmd(ECREATE, 2'd0, 64'h500, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL ecreate_e0_500: status=%0d need 0", st); end
    endtask

    task automatic test_report_hold();
        logic [1:0] st; logic [63:0] d; int lat; int waits;
        cmd_op    = EREPORT;
        cmd_eid   = 2'd1;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        waits = 0;
        while (!resp_valid && waits < 10) begin
            @(posedge clk); #1;
            waits++;
        end
        for (int c = 0; c < 3; c++) begin
            total++;
            $display("ereport hold cycle=%0d rv=%b ready=%b data=%h", c, resp_valid, cmd_ready, resp_data);
            if (resp_valid !== 1'b1 || cmd_ready !== 1'b0 || resp_status !== 2'd0
                || resp_data !== 64'h14B) begin
                bad++;
                $display("FAIL ereport_hold%0d: rv=%b ready=%b st=%0d data=%h, need 1/0/0/14b",
                         c, resp_valid, cmd_ready, resp_status, resp_data);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        total++;
        if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ereport_release: rv=%b ready=%b need 0/1", resp_valid, cmd_ready);
        end
        do_cmd(EREPORT, 2'd2, 64'h0, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd1 || d !== 64'h0) begin
            bad++;
            $display("FAIL ereport_free: status=%0d data=%h need 1/0", st, d);
        end
    endtask

    task automatic test_destroy();
        logic [1:0] st; logic [63:0] d; int lat;
        do_cmd(EEXIT, 2'd1, 64'h0, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd0 || active !== 1'b0 || active_eid !== 2'd0) begin
            bad++;
            $display("FAIL eexit_e1: status=%0d active=%b eid=%0d need 0/0/0", st, active, active_eid);
        end
        access_valid = 1'b1;
        access_addr  = 64'h300;
        #1;
        total++;
        if (access_fault !== 1'b0) begin
            bad++;
            $display("FAIL access_outside: fault=%b need 0", access_fault);
        end
        access_valid = 1'b0;
        @(posedge clk); #1;
        do_cmd(EDESTROY, 2'd1, 64'h0, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd0 || lat !== 258) begin
            bad++;
            $display("FAIL edestroy_e1: status=%0d lat=%0d need 0/258", st, lat);
        end
        do_cmd(ECREATE, 2'd2, 64'h100, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL ecreate_e2_100: status=%0d need 0", st); end
        do_cmd(EADD, 2'd2, 64'h200, 64'h7, st, d, lat);
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL eadd_e2_200: status=%0d need 0", st); end
        do_cmd(EADD, 2'd2, 64'h500, 64'h7, st, d, lat);
        total++;
        if (st !== 2'd2) begin bad++; $display("FAIL eadd_e2_500_owned: status=%0d need 2", st); end
        do_cmd(EREPORT, 2'd1, 64'h0, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd1) begin bad++; $display("FAIL ereport_destroyed: status=%0d need 1", st); end
    endtask

    task automatic test_reset_mid_sweep();
        logic [1:0] st; logic [63:0] d; int lat; int seen;
        cmd_op    = EDESTROY;
        cmd_eid   = 2'd2;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        $display("mid-sweep reset: ready=%b rv=%b st=%0d act=%b", cmd_ready, resp_valid, resp_status, active);
        if ({cmd_ready, resp_valid, resp_status, resp_data, active, active_eid}
            !== {1'b1, 1'b0, 2'd0, 64'd0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL sweep_reset_outputs: ready=%b rv=%b st=%0d data=%h act=%b eid=%0d",
                     cmd_ready, resp_valid, resp_status, resp_data, active, active_eid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL sweep_reset_no_resp: resp_valid cycles=%0d need 0", seen);
        end
        do_cmd(ECREATE, 2'd0, 64'h500, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL post_reset_ecreate_e0: status=%0d need 0", st); end
        do_cmd(ECREATE, 2'd2, 64'h200, 64'h0, st, d, lat);
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL post_reset_ecreate_e2: status=%0d need 0", st); end
    endtask

    initial begin
        test_reset();
        test_lifecycle();
        test_access();
        test_errors();
        test_report_hold();
        test_destroy();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
